seven_seg_mux: RTL and testbench

Parametrised multiplexed seven-segment driver for DIGITS common-anode digits with active-low segments and anodes. It scans the digits at a programmable refresh rate and decodes 4-bit hex nibbles to segment patterns. On top of plain scanning it provides per-digit decimal points, per-digit blanking, leading-zero suppression, anti-ghosting guard cycles and frame-synchronous message capture. It sits between the application datapath and the board's display pins.

---
 rtl/seven_seg_mux.sv | 165 ++++++++++++++++
 tb/tb_seven_seg_mux.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// Multiplexed common-anode seven-segment driver with per-digit dp/blank, leading-zero
// suppression, guard cycles and frame-synchronous capture. Optional PWM dimming: SEVEN_SEG_MUX_DIM_EN.
module seven_seg_mux #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 65536,
  parameter int unsigned GUARD       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   msg,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [DW-1:0]       dig;
  logic [4*DIGITS-1:0] msg_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   blank_q;
  logic                snap_d;

  logic                slot_end;
  logic                frame_wrap;
  logic                gate;

  logic [3:0]          nib;
  logic                dp_sel;
  logic                blank_sel;
  logic                supp_sel;
  logic [DIGITS-1:0]   supp;
  logic                zero_above;
  logic                lit;
  logic [DIGITS-1:0]   an_next;

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (dig == DIG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      dig     <= '0;
      msg_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      snap_d  <= 1'b0;
    end else begin
      cnt    <= slot_end ? '0 : cnt + 1'b1;
      snap_d <= frame_wrap;
      if (slot_end) begin
        dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
      end
      if (frame_wrap) begin
        msg_q   <= msg;
        dp_q    <= dp_in;
        blank_q <= blank;
      end
    end
  end

`ifdef SEVEN_SEG_MUX_DIM_EN
  logic [3:0] pwm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= '0;
    end else begin
      pwm <= pwm + 4'd1;
    end
  end

  assign gate = (pwm < bright);
`else
  logic bright_unused;

  assign bright_unused = ^bright;
  assign gate          = 1'b1;
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Digit i is suppressed only while every nibble from i up to the top is zero.
  always_comb begin
    zero_above = 1'b1;
    supp       = '0;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (msg_q[4*i +: 4] == 4'h0);
      supp[i]    = lz_en && zero_above;
    end
  end

  always_comb begin
    nib       = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    supp_sel  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dig == DW'(i)) begin
        nib       = msg_q[4*i +: 4];
        dp_sel    = dp_q[i];
        blank_sel = blank_q[i];
        supp_sel  = supp[i];
      end
    end
  end

  // A requested decimal point keeps an otherwise suppressed digit lit.
  assign lit = (cnt >= CNT_GUARD) && !blank_sel && (!supp_sel || dp_sel) && gate;

  always_comb begin
    an_next = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (lit && (dig == DW'(i))) begin
        an_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an    <= '1;
      seg   <= '1;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      an    <= an_next;
      seg   <= hex_to_seg(nib);
      dp    <= ~dp_sel;
      frame <= snap_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux (DIGITS=4, REFRESH_DIV=8, GUARD=1); dimming checks
// follow SEVEN_SEG_MUX_DIM_EN when it is defined for the build.
module tb_seven_seg_mux;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned RD     = 8;
  localparam int unsigned GUARD  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] msg;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        lz_en;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  seven_seg_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .msg(msg), .dp_in(dp_in), .blank(blank), .lz_en(lz_en),
    .bright(bright), .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic gate_open(input int unsigned k, input logic [3:0] b);
`ifdef SEVEN_SEG_MUX_DIM_EN
    return (k % 16) < b;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [3:0] exp_an(input int unsigned d, input int unsigned c, input logic on);
    logic [3:0] a;
    a = 4'hF;
    if (c >= GUARD && on) a[d] = 1'b0;
    return a;
  endfunction

  // Skips a pulse that may belong to a snapshot taken before the caller's input change.
  task automatic wait_frame();
    int unsigned t;
    @(negedge clk);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame && t < 80);
    check("frame_seen", {31'd0, frame}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] m;
    logic [3:0]  dpv;
    logic [3:0]  blk;
    logic        lz;
    int unsigned d;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t tv [22];
  logic [6:0] seg_1234 [4];
  logic [6:0] seg_abcd [4];

  initial begin
    tv[0]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'h19, 1'b1};
    tv[1]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 1, 4'b1101, 7'h30, 1'b1};
    tv[2]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 2, 4'b1011, 7'h24, 1'b1};
    tv[3]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'h79, 1'b1};
    tv[4]  = '{16'hEF67, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'h78, 1'b1};
    tv[5]  = '{16'hEF67, 4'h0, 4'h0, 1'b0, 1, 4'b1101, 7'h02, 1'b1};
    tv[6]  = '{16'hEF67, 4'h0, 4'h0, 1'b0, 2, 4'b1011, 7'h0E, 1'b1};
    tv[7]  = '{16'hEF67, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'h06, 1'b1};
    tv[8]  = '{16'h0898, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'h00, 1'b1};
    tv[9]  = '{16'h0898, 4'h0, 4'h0, 1'b0, 1, 4'b1101, 7'h10, 1'b1};
    tv[10] = '{16'h0898, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'h40, 1'b1};
    tv[11] = '{16'h0050, 4'h0, 4'h0, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
    tv[12] = '{16'h0050, 4'h0, 4'h0, 1'b1, 1, 4'b1101, 7'h12, 1'b1};
    tv[13] = '{16'h0050, 4'h0, 4'h0, 1'b1, 2, 4'b1111, 7'h40, 1'b1};
    tv[14] = '{16'h0050, 4'h0, 4'h0, 1'b1, 3, 4'b1111, 7'h40, 1'b1};
    tv[15] = '{16'h0050, 4'h4, 4'h0, 1'b1, 2, 4'b1011, 7'h40, 1'b0};
    tv[16] = '{16'h0000, 4'h0, 4'h0, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
    tv[17] = '{16'h0000, 4'h0, 4'h0, 1'b1, 1, 4'b1111, 7'h40, 1'b1};
    tv[18] = '{16'h0000, 4'h0, 4'h1, 1'b1, 0, 4'b1111, 7'h40, 1'b1};
    tv[19] = '{16'h1030, 4'h0, 4'h0, 1'b1, 2, 4'b1011, 7'h40, 1'b1};
    tv[20] = '{16'h1234, 4'hA, 4'h0, 1'b0, 1, 4'b1101, 7'h30, 1'b0};
    tv[21] = '{16'h1234, 4'h0, 4'h4, 1'b0, 2, 4'b1111, 7'h24, 1'b1};

    seg_1234 = '{7'h19, 7'h30, 7'h24, 7'h79};
    seg_abcd = '{7'h21, 7'h46, 7'h03, 7'h08};

    rst = 1'b1; msg = 16'h1234; dp_in = '0; blank = '0; lz_en = 1'b0; bright = 4'd15;
    repeat (2) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_frame", {31'd0, frame}, 32'd0);
    rst = 1'b0;

    // Reset release, first frame at output cycle 32, then a mid-frame msg change at digit 2.
    for (int unsigned n = 0; n < 128; n++) begin
      int unsigned d;
      int unsigned c;
      logic [6:0]  es;
      @(negedge clk);
      d  = (n / RD) % DIGITS;
      c  = n % RD;
      es = (n < 32) ? 7'h40 : ((n < 96) ? seg_1234[d] : seg_abcd[d]);
      check("scan_an", {28'd0, an}, {28'd0, exp_an(d, c, gate_open(n, bright))});
      check("scan_seg", {25'd0, seg}, {25'd0, es});
      check("scan_dp", {31'd0, dp}, 32'd1);
      check("scan_frame", {31'd0, frame}, {31'd0, (n % 32 == 0) && (n > 0)});
      if (n == 83) msg = 16'hABCD;
    end

    // Asynchronous reset in the middle of digit 2's lit window.
    repeat (19) @(negedge clk);
    check("pre_rst_an", {28'd0, an}, {28'd0, exp_an(2, 2, gate_open(146, bright))});
    rst = 1'b1;
    #1;
    check("async_an", {28'd0, an}, 32'hF);
    check("async_seg", {25'd0, seg}, 32'h7F);
    check("async_dp", {31'd0, dp}, 32'd1);
    check("async_frame", {31'd0, frame}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned n = 0; n < 10; n++) begin
      @(negedge clk);
      check("restart_an", {28'd0, an}, {28'd0, exp_an(n / RD, n % RD, gate_open(n, bright))});
      check("restart_seg", {25'd0, seg}, 32'h40);
    end

    // Static patterns: guard cycle and mid-lit cycle of the selected digit.
    for (int unsigned v = 0; v < 22; v++) begin
      msg = tv[v].m; dp_in = tv[v].dpv; blank = tv[v].blk; lz_en = tv[v].lz;
      wait_frame();
      repeat (RD * tv[v].d) @(negedge clk);
      check("tv_guard_an", {28'd0, an}, 32'hF);
      check("tv_guard_seg", {25'd0, seg}, {25'd0, tv[v].seg});
      repeat (3) @(negedge clk);
      check("tv_an", {28'd0, an}, {28'd0, tv[v].an});
      check("tv_seg", {25'd0, seg}, {25'd0, tv[v].seg});
      check("tv_dp", {31'd0, dp}, {31'd0, tv[v].dp});
    end

    // Brightness gate over whole frames.
    msg = 16'h1234; dp_in = '0; blank = '0; lz_en = 1'b0;
    for (int unsigned b = 0; b < 2; b++) begin
      bright = (b == 0) ? 4'd4 : 4'd0;
      wait_frame();
      for (int unsigned k = 0; k < 32; k++) begin
        if (k > 0) @(negedge clk);
        check("dim_an", {28'd0, an}, {28'd0, exp_an(k / RD, k % RD, gate_open(k, bright))});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
